// File: rtl/huff_pkg.sv
// Shared constants and FSM state type for the Huffman encoder.
// SRAM layout: code lengths at LEN_BASE+sym, MSB-aligned code bits at CODE_BASE+sym.
package huff_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_IN,
    S_RD_LEN,
    S_WAIT_LEN,
    S_GET_LEN,
    S_RD_CODE,
    S_WAIT_CODE,
    S_GET_CODE,
    S_EMIT,
    S_FLUSH,
    S_DONE
  } he_state_t;

  localparam logic [9:0] LEN_BASE  = 10'd0;
  localparam logic [9:0] CODE_BASE = 10'd128;
  localparam logic [9:0] TREE_BASE = 10'd256;

  localparam int MAX_CODE_LEN = 8;
  localparam int PAD_W        = 3;

endpackage

// File: rtl/bit_packer.sv
// MSB-first bit accumulator: ORs a masked variable-length code below the bits
// already held and hands out the top byte on request.
module bit_packer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic [7:0] code,
  input  logic [3:0] len,
  input  logic       pop,
  input  logic       clear,
  output logic [7:0] byte_out,
  output logic [3:0] bitcnt,
  output logic       have_byte
);

  logic [15:0] r_acc;
  logic [3:0]  r_bitcnt;
  logic [7:0]  w_mask;
  logic [15:0] w_shifted;

  // Only the top len bits of the code word are meaningful.
  assign w_mask    = ~(8'hFF >> len);
  assign w_shifted = {code & w_mask, 8'h00} >> r_bitcnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc    <= '0;
      r_bitcnt <= '0;
    end else if (clear) begin
      r_acc    <= '0;
      r_bitcnt <= '0;
    end else if (load) begin
      r_acc    <= r_acc | w_shifted;
      r_bitcnt <= r_bitcnt + len;
    end else if (pop) begin
      r_acc    <= {r_acc[7:0], 8'h00};
      r_bitcnt <= r_bitcnt - 4'd8;
    end
  end

  assign byte_out  = r_acc[15:8];
  assign bitcnt    = r_bitcnt;
  assign have_byte = (r_bitcnt >= 4'd8);

endmodule

// File: rtl/huffman_encode.sv
// Huffman encoder: looks up length/code per symbol in SRAM and packs codes into bytes.
// Define HUFF_LEN_CHECK_EN to flag and drop symbols whose code length is 0 or above 8.
module huffman_encode
  import huff_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             HE_start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [7:0]       SR_data,
  output logic [9:0]       HE_addr,
  output logic             HE_R,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [PAD_W-1:0] out_pad,
  input  logic             out_ready,
  output logic             HE_done,
  output logic             HE_err
);

  he_state_t        r_state;
  logic [7:0]       r_sym;
  logic             r_last;
  logic [3:0]       r_len;
  logic [9:0]       r_addr;
  logic             r_rd;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_last;
  logic [PAD_W-1:0] r_out_pad;
  logic             r_done;

  logic [7:0] w_byte;
  logic [3:0] w_bitcnt;
  logic       w_have_byte;
  logic       w_load;
  logic       w_pop;
  logic       w_clear;
  logic [4:0] w_sum;

`ifdef HUFF_LEN_CHECK_EN
  logic r_err;
  logic w_len_bad;
  assign w_len_bad = (SR_data[3:0] == 4'd0) || (SR_data[3:0] > 4'(MAX_CODE_LEN));
  assign HE_err    = r_err;
`else
  assign HE_err = 1'b0;
`endif

  assign w_clear = (r_state == S_IDLE) && HE_start;
  assign w_load  = (r_state == S_GET_CODE);
  assign w_pop   = (r_state == S_EMIT) && out_ready && w_have_byte;
  // Bit count after the pending load, widened so the EMIT decision never wraps.
  assign w_sum   = {1'b0, w_bitcnt} + {1'b0, r_len};

  bit_packer u_packer (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (w_load),
    .code      (SR_data),
    .len       (r_len),
    .pop       (w_pop),
    .clear     (w_clear),
    .byte_out  (w_byte),
    .bitcnt    (w_bitcnt),
    .have_byte (w_have_byte)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_sym       <= '0;
      r_last      <= 1'b0;
      r_len       <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_pad   <= '0;
      r_done      <= 1'b0;
`ifdef HUFF_LEN_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (HE_start) begin
            r_state    <= S_WAIT_IN;
            r_in_ready <= 1'b1;
`ifdef HUFF_LEN_CHECK_EN
            r_err      <= 1'b0;
`endif
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            r_sym      <= in_data;
            r_last     <= in_last;
            r_in_ready <= 1'b0;
            r_state    <= S_RD_LEN;
          end
        end
        S_RD_LEN: begin
          r_addr  <= LEN_BASE + {2'b00, r_sym};
          r_rd    <= 1'b1;
          r_state <= S_WAIT_LEN;
        end
        S_WAIT_LEN: r_state <= S_GET_LEN;
        S_GET_LEN: begin
          r_addr <= '0;
          r_rd   <= 1'b0;
`ifdef HUFF_LEN_CHECK_EN
          if (w_len_bad) begin
            r_err <= 1'b1;
            if (r_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_state    <= S_WAIT_IN;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_len   <= SR_data[3:0];
            r_state <= S_RD_CODE;
          end
`else
          r_len   <= SR_data[3:0];
          r_state <= S_RD_CODE;
`endif
        end
        S_RD_CODE: begin
          r_addr  <= CODE_BASE + {2'b00, r_sym};
          r_rd    <= 1'b1;
          r_state <= S_WAIT_CODE;
        end
        S_WAIT_CODE: r_state <= S_GET_CODE;
        S_GET_CODE: begin
          r_addr <= '0;
          r_rd   <= 1'b0;
          if (w_sum >= 5'd8) begin
            r_state     <= S_EMIT;
            r_out_valid <= 1'b1;
            r_out_last  <= r_last && (w_sum == 5'd8);
            r_out_pad   <= '0;
          end else if (r_last) begin
            r_state <= S_FLUSH;
          end else begin
            r_state    <= S_WAIT_IN;
            r_in_ready <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_pop) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (r_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_state    <= S_WAIT_IN;
              r_in_ready <= 1'b1;
            end
          end
        end
        // First FLUSH cycle decides whether a padded tail byte exists.
        S_FLUSH: begin
          if (!r_out_valid) begin
            if (w_bitcnt == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b1;
              r_out_pad   <= PAD_W'(4'd8 - w_bitcnt);
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_pad   <= '0;
            r_state     <= S_DONE;
            r_done      <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign HE_addr   = r_addr;
  assign HE_R      = r_rd;
  assign out_valid = r_out_valid;
  assign out_data  = w_byte;
  assign out_last  = r_out_last;
  assign out_pad   = r_out_pad;
  assign HE_done   = r_done;

endmodule

// File: tb/tb_huffman_encode.sv
// Bench for huffman_encode: directed table cases plus random streams compared
// against a bit-queue reference encoder.
module tb_huffman_encode;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       HE_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [7:0] SR_data;
  logic [9:0] HE_addr;
  logic       HE_R;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] out_pad;
  logic       out_ready = 1'b0;
  logic       HE_done;
  logic       HE_err;

  logic [7:0] sram [0:1023];
  logic [3:0] lenTab [0:255];
  logic [7:0] codeTab [0:255];

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  bit lenCheck = 1'b0;

  logic [7:0] gotData [$];
  bit         gotLast [$];
  logic [2:0] gotPad [$];
  logic [7:0] stimSyms [$];

  huffman_encode dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .HE_start  (HE_start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .SR_data   (SR_data),
    .HE_addr   (HE_addr),
    .HE_R      (HE_R),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_pad   (out_pad),
    .out_ready (out_ready),
    .HE_done   (HE_done),
    .HE_err    (HE_err)
  );

  always #5 clk = ~clk;

  assign SR_data = sram[HE_addr];

  // Records every byte accepted downstream and every HE_done pulse.
  always @(negedge clk) begin
    if (n_rst) begin
      if (out_valid && out_ready) begin
        gotData.push_back(out_data);
        gotLast.push_back(out_last);
        gotPad.push_back(out_pad);
      end
      if (HE_done) doneCount++;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setEntry(input logic [7:0] sym, input logic [3:0] len, input logic [7:0] code);
    lenTab[sym]             = len;
    codeTab[sym]            = code;
    sram[{2'b00, sym}]      = {4'h0, len};
    sram[10'd128 + {2'b00, sym}] = code;
  endtask

  task automatic sendSym(input logic [7:0] s, input bit last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = s;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkVal("inReadyWait", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    HE_start = 1'b1;
    @(negedge clk);
    HE_start = 1'b0;
  endtask

  // readyMode 0: random out_ready, 1: out_ready always high.
  task automatic applyStimulus(input int readyMode);
    gotData.delete();
    gotLast.delete();
    gotPad.delete();
    doneCount = 0;
    pulseStart();
    fork
      begin
        foreach (stimSyms[i]) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          sendSym(stimSyms[i], i == stimSyms.size() - 1);
        end
      end
      begin
        int n;
        n = 0;
        while (doneCount == 0 && n < 3000) begin
          @(posedge clk);
          #1;
          out_ready = (readyMode != 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          n++;
        end
        checkVal("doneWait", 32'(doneCount != 0), 32'd1);
      end
    join
    repeat (3) @(negedge clk);
  endtask

  // Reference: concatenate each symbol's top len code bits, cut into bytes, zero-pad the tail.
  task automatic checkOutput(input string tag);
    bit         bq [$];
    bit         expErr;
    int         nb;
    int         nBits;
    int         L;
    logic [7:0] c;
    logic [7:0] v;
    expErr = 1'b0;
    foreach (stimSyms[i]) begin
      L = int'(lenTab[stimSyms[i]]);
      c = codeTab[stimSyms[i]];
      if (lenCheck && (L == 0 || L > 8)) begin
        expErr = 1'b1;
        continue;
      end
      for (int k = 0; k < L; k++) bq.push_back(c[7-k]);
    end
    nBits = bq.size();
    nb = (nBits + 7) / 8;
    checkVal({tag, ".nBytes"}, 32'(gotData.size()), 32'(nb));
    for (int b = 0; b < nb && b < gotData.size(); b++) begin
      v = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (b * 8 + k < nBits) v[7-k] = bq[b*8+k];
      end
      checkVal($sformatf("%s.byte%0d", tag, b), 32'(gotData[b]), 32'(v));
      checkVal($sformatf("%s.last%0d", tag, b), 32'(gotLast[b]), 32'(b == nb - 1));
      if (b == nb - 1)
        checkVal($sformatf("%s.pad", tag), 32'(gotPad[b]), 32'(nb * 8 - nBits));
    end
    checkVal({tag, ".done"}, 32'(doneCount), 32'd1);
    checkVal({tag, ".err"}, 32'(HE_err), 32'(expErr));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, ".addr"},     32'(HE_addr),   32'd0);
    checkVal({tag, ".rd"},       32'(HE_R),      32'd0);
    checkVal({tag, ".inReady"},  32'(in_ready),  32'd0);
    checkVal({tag, ".outValid"}, 32'(out_valid), 32'd0);
    checkVal({tag, ".outData"},  32'(out_data),  32'd0);
    checkVal({tag, ".outLast"},  32'(out_last),  32'd0);
    checkVal({tag, ".outPad"},   32'(out_pad),   32'd0);
    checkVal({tag, ".done"},     32'(HE_done),   32'd0);
    checkVal({tag, ".err"},      32'(HE_err),    32'd0);
  endtask

  initial begin
    int n;
    int savedDone;
    logic [7:0] s;
`ifdef HUFF_LEN_CHECK_EN
    lenCheck = 1'b1;
`endif
    for (int i = 0; i < 1024; i++) sram[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      lenTab[i]  = 4'd0;
      codeTab[i] = 8'h00;
    end
    setEntry(8'h41, 4'd2, 8'h40);
    setEntry(8'h42, 4'd1, 8'h80);
    setEntry(8'h43, 4'd3, 8'h00);
    setEntry(8'h50, 4'd8, 8'hA5);
    for (int i = 0; i < 64; i++)
      setEntry(8'(i), 4'($urandom_range(1, 8)), 8'($urandom));

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    stimSyms = '{8'h41, 8'h42, 8'h41, 8'h43};
    applyStimulus(1);
    checkOutput("tableA");

    stimSyms = '{8'h41, 8'h41, 8'h41};
    applyStimulus(0);
    checkOutput("pad2");

    stimSyms = '{8'h42, 8'h50, 8'h50, 8'h42};
    applyStimulus(0);
    checkOutput("tableB");

    // Backpressure: a len-8 last symbol parks a full byte in EMIT.
    gotData.delete();
    gotLast.delete();
    gotPad.delete();
    doneCount = 0;
    out_ready = 1'b0;
    stimSyms = '{8'h50};
    pulseStart();
    sendSym(8'h50, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal("bpValidSeen", 32'(n < 100), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkVal("bpData",    32'(out_data),  32'(codeTab[8'h50]));
      checkVal("bpInReady", 32'(in_ready),  32'd0);
      checkVal("bpValid",   32'(out_valid), 32'd1);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkVal("bpTransfer", 32'(out_valid), 32'd0);
    n = 0;
    while (doneCount == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("backpressure");

`ifdef HUFF_LEN_CHECK_EN
    setEntry(8'h44, 4'd0, 8'hFF);
    stimSyms = '{8'h41, 8'h44, 8'h41};
    applyStimulus(0);
    checkOutput("lenCheck");
`endif

    for (int r = 0; r < 6; r++) begin
      stimSyms.delete();
      for (int k = 0; k < $urandom_range(1, 6); k++) begin
        s = 8'($urandom_range(0, 63));
        stimSyms.push_back(s);
      end
      applyStimulus(0);
      checkOutput($sformatf("rand%0d", r));
    end

    // Reset in WAIT_CODE of the first symbol, then a clean session.
    doneCount = 0;
    out_ready = 1'b1;
    pulseStart();
    sendSym(8'h41, 1'b0);
    n = 0;
    while (!(HE_R && HE_addr == 10'd193) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal("rstWaitCode", 32'(n < 100), 32'd1);
    n_rst = 1'b0;
    #1;
    checkResetOutputs("midReset");
    savedDone = doneCount;
    repeat (3) @(negedge clk);
    checkVal("midReset.noDone", 32'(doneCount), 32'(savedDone));
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    stimSyms = '{8'h41, 8'h42, 8'h41, 8'h43};
    applyStimulus(0);
    checkOutput("afterReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_encode.md
# huffman_encode

Downstream consumer of the code table that `code_transform` leaves in SRAM.
- Once `CT_finish` has pulsed, this block takes a symbol stream in over a valid/ready handshake.
- For each symbol it looks up the code length at address sym and the MSB-aligned code bits at address 128+sym.
- It packs the variable-length codes MSB-first into bytes and sends them out over a second valid/ready handshake.
- It shares the SRAM read port protocol used by the other SRAM masters.

## Interface
Parameters:
- none; all constants are in `huff_pkg`.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- HE_start  in  1  one-cycle pulse that starts an encode session; ignored unless in IDLE
- in_valid  in  1  input symbol valid
- in_data  in  8  input symbol
- in_last  in  1  marks the final symbol of the session; qualified by in_valid
- in_ready  out  1  block accepts a symbol this cycle
- SR_data  in  8  SRAM read data
- HE_addr  out  10  SRAM address, registered
- HE_R  out  1  SRAM read strobe, registered
- out_valid  out  1  packed byte valid
- out_data  out  8  packed byte; the first code bit is in bit 7
- out_last  out  1  final byte of the session; qualified by out_valid
- out_pad  out  3  number of zero pad bits in the LSBs of the final byte; valid only with out_last
- out_ready  in  1  downstream accepts the byte
- HE_done  out  1  one-cycle pulse when the session completes
- HE_err  out  1  sticky flag for an invalid code length; cleared by HE_start

## Operation
States and transitions:
- IDLE → WAIT_IN on HE_start. Entering WAIT_IN clears acc, bitcnt and HE_err.
- WAIT_IN: in_ready=1. On in_valid, latch sym and last, then go to RD_LEN.
- RD_LEN → WAIT_LEN → GET_LEN: HE_addr=sym with HE_R=1 during WAIT_LEN and GET_LEN. In GET_LEN, sample len=SR_data[3:0].
- RD_CODE → WAIT_CODE → GET_CODE: same read sequence at HE_addr=128+sym. In GET_CODE, sample code=SR_data and pack it.
- Packing: mask code to its top len bits, then acc[15:0] |= {code,8'h00} >> bitcnt and bitcnt += len.
  - If bitcnt ≥ 8, go to EMIT.
  - Otherwise, if last, go to FLUSH.
  - Otherwise, go to WAIT_IN.
- EMIT: out_valid=1 with out_data=acc[15:8]. On out_ready, acc <<= 8 and bitcnt -= 8.
  - If last and bitcnt becomes 0, this byte carries out_last=1 and out_pad=0, and the next state is DONE.
  - Otherwise, if last, go to FLUSH.
  - Otherwise, go to WAIT_IN.
- FLUSH: if bitcnt=0, go straight to DONE. Otherwise out_valid=1, out_data=acc[15:8], out_last=1, out_pad=8−bitcnt; on out_ready, go to DONE.
- DONE: HE_done=1 for one cycle, then IDLE.
- Width rules: bitcnt is 4 bits and is always <8 before packing, so it never exceeds 15. At most one byte is emitted per symbol.
- HE_addr and HE_R return to 0 outside read states.

## Timing
- Reset values: HE_addr=0, HE_R=0, in_ready=0, out_valid=0, out_data=0, out_last=0, out_pad=0, HE_done=0, HE_err=0; state IDLE.
- SRAM reads: HE_R is high with HE_addr stable for exactly two cycles. SR_data is sampled in the second of those cycles.
- Latency: 7 cycles from the input handshake to the packed state, excluding EMIT.
- Throughput: one symbol per 8 cycles without backpressure.
- While out_valid=1 and out_ready=0, out_data, out_last and out_pad hold stable and in_ready=0.
- Reset mid-session aborts immediately. Partial bits are discarded and no HE_done pulses.
- HE_start outside IDLE is ignored.
- in_valid is ignored outside WAIT_IN.

## Configuration
- HUFF_LEN_CHECK_EN defined:
  - len=0 or len>8 sets HE_err.
  - The symbol is dropped with no code read and no bits packed.
  - If that symbol was last, go to FLUSH.
- Not defined:
  - HE_err is tied to 0.
  - len is used unchecked; behaviour for len outside 1..8 is undefined.

## Structure
- `huff_pkg` holds:
  - the state enum
  - LEN_BASE=10'd0, CODE_BASE=10'd128, TREE_BASE=10'd256
  - MAX_CODE_LEN=8, PAD_W=3
- One sub-module, `bit_packer`: holds acc and bitcnt.
  - Inputs: load, code, len, pop, clear.
  - Outputs: byte_out, bitcnt, have_byte.
- The FSM and SRAM sequencing stay in `huffman_encode`.

## Test plan
- Table: 0x41 len2 code 0x40; 0x42 len1 code 0x80; 0x43 len3 code 0x00. Stream 41,42,41,43(last) → single byte 0x68 with out_last=1, out_pad=0, then HE_done.
- Stream 41,41,41(last) → byte 0x54 with out_last=1, out_pad=2.
- Table: 0x42 len1 code 0x80; 0x50 len8 code 0xA5. Stream 42,50,50,42(last) → bytes 0xD2, 0xD2, 0xC0; the last byte has out_last=1, out_pad=6.
- Hold out_ready=0 for 5 cycles during EMIT → out_data stable and in_ready=0 throughout; the byte transfers on the first out_ready cycle.
- With HUFF_LEN_CHECK_EN, table 0x44 len0. Stream 41,44,41(last) → HE_err=1; output byte 0x50, out_pad=4.
- Assert n_rst low during WAIT_CODE → all outputs return to reset values. A fresh HE_start then encodes correctly.
